reg_bank: RTL
=============

# reg_bank

Parametrised multi-entry register bank: the successor to the team's single 32-bit hold register. It provides one write port with per-lane write masks and two independent combinational read ports, with optional same-cycle write bypass and an optional hardwired-zero entry 0. A sequenced clear engine zeroes every entry at one entry per cycle and reports progress on `busy`. The bank sits in the datapath as the general-purpose register file between decode and the ALU.

## Interface
- `WIDTH`, 32: data bits per entry; must be a multiple of `LANE`.
- `LANE`, 8: bits per write-mask lane; `NL = WIDTH/LANE` lanes.
- `DEPTH`, 16: number of entries, 2..256, need not be a power of 2.
- `AW`, 4: address width; must satisfy `2^AW >= DEPTH`.
- `BYPASS`, 1: 1 = read ports forward same-cycle write data; 0 = reads show pre-write contents.
- `ZERO_REG`, 0: 1 = entry 0 always reads 0 and ignores writes and clears.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `we` in 1: write request.
- `waddr` in AW: write address.
- `wdata` in WIDTH: write data.
- `wmask` in NL: per-lane write enable; bit i covers `wdata[i*LANE +: LANE]`.
- `raddr_a` in AW: read address, port A.
- `rdata_a` out WIDTH: read data, port A (combinational).
- `raddr_b` in AW: read address, port B.
- `rdata_b` out WIDTH: read data, port B (combinational).
- `clr` in 1: start-clear request, sampled on the edge.
- `busy` out 1: clear sweep in progress.

## Operation
- **Reset.** `rst`=0 asynchronously zeroes all entries, puts the FSM in IDLE, and sets `busy`=0 and the sweep counter to 0. Both `rdata` ports then read 0.
- **Write.** On an edge with `we`=1, `busy`=0, `waddr<DEPTH` and a nonzero mask, only the lanes with `wmask[i]`=1 are updated; the other lanes hold.
  - `waddr>=DEPTH` drops the write.
  - `ZERO_REG`=1 with `waddr`=0 drops the write.
  - `wmask`=0 is a no-op.
- **Read.**
  - `rdata_x` = `entry[raddr_x]`.
  - `raddr_x>=DEPTH` reads 0.
  - `ZERO_REG`=1 with `raddr_x`=0 reads 0.
  - Both ports may address the same entry.
- **Bypass.** With `BYPASS`=1, if a write would be accepted this cycle and `raddr_x==waddr`, then `rdata_x` returns the merge: `wdata` on the masked lanes, stored data on the rest. With `BYPASS`=0, the new value appears the cycle after the edge.
- **Clear FSM.**
  - IDLE: `clr`=1 on an edge moves to SWEEP, sets counter to 0 and `busy`=1.
  - SWEEP: each edge zeroes `entry[counter]` and increments the counter. After the edge that zeroes entry `DEPTH-1`, return to IDLE with `busy`=0.
  - `clr` during SWEEP is ignored; the sweep does not restart.
  - `we` during SWEEP is dropped entirely, including writes to entries already cleared.
- **Reads during SWEEP** return current contents: entries below the counter read 0, entries at or above it read old data.
- **Reset mid-sweep** clears everything immediately and returns to IDLE.

## Timing
- Write-to-read latency: 0 cycles with `BYPASS`=1, 1 cycle with `BYPASS`=0. Reads are combinational from address.
- `busy` rises on the edge that samples `clr` and stays high for exactly `DEPTH` cycles.
- A write is accepted on the first edge where `busy`=0 after the sweep.
- `clr` and `we` together in IDLE: the write is accepted on that same edge, then the sweep zeroes its entry later.
- The counter is `AW` bits wide and never wraps past `DEPTH-1`.

## Test plan
- **Reset and full write.** Assert `rst`=0 mid-run, then release. Write 0xDEADBEEF to entry 3 with `wmask`=1111. Reading entry 3 on port A next cycle returns 0xDEADBEEF; port B at entry 4 returns 0.
- **Masked write.** Entry 3 holds 0xDEADBEEF. Write `wdata`=0x11223344 with `wmask`=0101. Entry 3 reads 0xDE22BE44.
- **Bypass.** With `BYPASS`=1, write 0xCAFEF00D to entry 5 with both read ports at 5: both return 0xCAFEF00D in the same cycle. With `BYPASS`=0, they return the old value that cycle and the new value next cycle.
- **Boundaries.**
  - `DEPTH`=10: a write to address 12 is dropped and a read of 12 returns 0.
  - `ZERO_REG`=1: a write of 0xFFFFFFFF to entry 0 leaves entry 0 reading 0.
- **Clear sweep.**
  - Fill all 16 entries with nonzero values, then pulse `clr`. `busy` is high for exactly 16 cycles.
  - Mid-sweep, with counter=6: entry 5 reads 0 and entry 6 reads its old value.
  - A `we` and a second `clr` during the sweep are both ignored.
  - After the sweep, all entries read 0.
- **Reset mid-sweep and simultaneous events.**
  - Assert `rst` low at counter=7: `busy` falls at once and all entries read 0.
  - `clr` and `we` on the same IDLE edge: the write lands, then is zeroed when the sweep reaches its entry.

Source files
------------

// File: rtl/reg_bank_if.sv
// reg_bank_if: bus bundle for the register bank.
//   master : drives we/waddr/wdata/wmask, raddr_a/raddr_b, clr; observes rdata_a/rdata_b, busy
//   slave  : the bank side of the same signals
interface reg_bank_if #(
  parameter int WIDTH = 32,
  parameter int LANE  = 8,
  parameter int AW    = 4
);
  localparam int NL = WIDTH / LANE;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [NL-1:0]    wmask;
  logic [AW-1:0]    raddr_a;
  logic [WIDTH-1:0] rdata_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_b;
  logic             clr;
  logic             busy;

  modport master (output we, waddr, wdata, wmask, raddr_a, raddr_b, clr,
                  input  rdata_a, rdata_b, busy);
  modport slave  (input  we, waddr, wdata, wmask, raddr_a, raddr_b, clr,
                  output rdata_a, rdata_b, busy);
endinterface

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register file, one lane-masked write port, two
// combinational read ports, optional write bypass and hardwired-zero entry 0,
// plus a one-entry-per-cycle clear sweep.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   bus   : reg_bank_if.slave (write port, read ports A/B, clr, busy)
module reg_bank #(
  parameter int WIDTH    = 32,
  parameter int LANE     = 8,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic     clk,
  input  logic     rst,
  reg_bank_if.slave bus
);
  localparam int            NL      = WIDTH / LANE;
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  state_t                      r_state;
  logic [AW-1:0]               r_cnt;
  logic                        r_busy;

  logic [WIDTH-1:0] w_bmask;
  logic             w_addr_ok;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_wold;
  logic [WIDTH-1:0] w_wnew;
  logic [WIDTH-1:0] w_ra;
  logic [WIDTH-1:0] w_rb;

  for (genvar l = 0; l < NL; l++) begin : g_lane
    assign w_bmask[l*LANE +: LANE] = {LANE{bus.wmask[l]}};
  end

  // Address decode by compare so out-of-range addresses simply match nothing.
  function automatic logic [WIDTH-1:0] rd_entry(input logic [AW-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++)
      if (a == AW'(i)) v = r_mem[i];
    if (ZERO_REG != 0 && a == '0) v = '0;
    return v;
  endfunction

  assign w_addr_ok = ({1'b0, bus.waddr} < DEPTH_L) &&
                     !(ZERO_REG != 0 && bus.waddr == '0);
  assign w_wr_ok   = bus.we && !r_busy && w_addr_ok && (|bus.wmask);
  assign w_wold    = rd_entry(bus.waddr);
  assign w_wnew    = (w_wold & ~w_bmask) | (bus.wdata & w_bmask);

  assign w_ra = rd_entry(bus.raddr_a);
  assign w_rb = rd_entry(bus.raddr_b);

  // Bypass value is the full merged word, so unmasked lanes show stored data.
  assign bus.rdata_a = (BYPASS != 0 && w_wr_ok && bus.raddr_a == bus.waddr) ? w_wnew : w_ra;
  assign bus.rdata_b = (BYPASS != 0 && w_wr_ok && bus.raddr_b == bus.waddr) ? w_wnew : w_rb;
  assign bus.busy    = r_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem   <= '0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.clr) begin
          r_state <= SWEEP;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
        SWEEP: if (r_cnt == LAST) begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
      // Writes are gated by busy, so sweep and write never hit the same edge.
      for (int i = 0; i < DEPTH; i++) begin
        if (r_state == SWEEP && r_cnt == AW'(i))
          r_mem[i] <= '0;
        else if (w_wr_ok && bus.waddr == AW'(i))
          r_mem[i] <= w_wnew;
      end
    end
  end
endmodule
